// File: rtl/sieve_pkg.sv
// Shared types and defaults for the sieve prime scheduler.
package sieve_pkg;

    localparam int unsigned DEF_AW     = 20;
    localparam int unsigned DEF_N      = 999999;
    localparam int unsigned DEF_RD_LAT = 2;
    // Width needed to hold i*i without truncation.
    localparam int unsigned DEF_SQ_W   = 2 * DEF_AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PROBE = 3'd2,
        S_MARK  = 3'd3,
        S_SCAN  = 3'd4,
        S_HOLD  = 3'd5,
        S_FIN   = 3'd6
    } sieve_state_t;

    function automatic int unsigned sq_width(input int unsigned aw);
        return 2 * aw;
    endfunction

endpackage

// File: rtl/sieve_rd_wait.sv
// Read-latency timer: load starts a countdown of RD_LAT cycles; done pulses
// in the cycle where the external RAM's read data for the loaded address is valid.
module sieve_rd_wait
    import sieve_pkg::*;
#(
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = $clog2(RD_LAT + 1);

    logic [CW-1:0] cnt;

    // Countdown from RD_LAT; done fires one cycle after the count reaches 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt <= CW'(RD_LAT);
            end else if (cnt != '0) begin
                cnt  <= cnt - 1'b1;
                done <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/sieve_scheduler.sv
// Sieve of Eratosthenes over an external 1-bit RAM, then paced enumeration
// of the primes found. Optional macro SIEVE_PRIME_COUNT_EN adds prime_cnt.
module sieve_scheduler
    import sieve_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    output logic          busy,
    output logic          done,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic          ram_rdata,
    output logic [AW-1:0] prime_o,
    output logic          prime_valid
`ifdef SIEVE_PRIME_COUNT_EN
    ,
    output logic [AW-1:0] prime_cnt
`endif
);

    localparam int unsigned     SQ_W = sq_width(AW);
    localparam logic [AW-1:0]   N_A  = AW'(N);
    localparam logic [AW:0]     N_X  = (AW + 1)'(N);
    localparam logic [SQ_W-1:0] N_SQ = SQ_W'(N);

    sieve_state_t    state;
    logic            waiting;
    logic [AW-1:0]   i;
    logic [AW:0]     j;
    logic [AW:0]     k;
    logic [AW:0]     i_x;
    logic [SQ_W-1:0] i_sq;
    logic            probe_past;
    logic            rd_load;
    logic            rd_done;
    logic            found_prime;

    // Square test at full width and read-timer launch for PROBE/SCAN.
    always_comb begin
        i_x         = {1'b0, i};
        i_sq        = SQ_W'(i) * SQ_W'(i);
        probe_past  = (i_sq > N_SQ);
        rd_load     = !waiting && (((state == S_PROBE) && !probe_past) ||
                                   ((state == S_SCAN) && (k <= N_X)));
        found_prime = (state == S_SCAN) && waiting && rd_done && !ram_rdata;
    end

    sieve_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
        .clk  (clk),
        .rst  (rst),
        .load (rd_load),
        .done (rd_done)
    );

    // Main sequencer: clear, sieve, then step through the primes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            waiting     <= 1'b0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_we      <= 1'b0;
            ram_waddr   <= '0;
            ram_wdata   <= 1'b0;
            ram_raddr   <= '0;
            prime_o     <= '0;
            prime_valid <= 1'b0;
        end else begin
            prime_valid <= 1'b0;
            case (state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        ram_we    <= 1'b1;
                        ram_wdata <= 1'b0;
                        ram_waddr <= '0;
                        // Park the read port off the first cleared address.
                        ram_raddr <= AW'(1);
                    end
                end
                S_CLEAR: begin
                    ram_raddr <= '0;
                    if (ram_waddr == N_A) begin
                        ram_we  <= 1'b0;
                        i       <= AW'(2);
                        waiting <= 1'b0;
                        state   <= S_PROBE;
                    end else begin
                        ram_waddr <= ram_waddr + 1'b1;
                    end
                end
                S_PROBE: begin
                    if (!waiting) begin
                        if (probe_past) begin
                            k     <= (AW + 1)'(2);
                            state <= S_SCAN;
                        end else begin
                            ram_raddr <= i;
                            waiting   <= 1'b1;
                        end
                    end else if (rd_done) begin
                        waiting <= 1'b0;
                        if (!ram_rdata) begin
                            j     <= {i, 1'b0};
                            state <= S_MARK;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (j <= N_X) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= 1'b1;
                        ram_waddr <= j[AW-1:0];
                        j         <= j + i_x;
                    end else begin
                        ram_we    <= 1'b0;
                        ram_wdata <= 1'b0;
                        i         <= i + 1'b1;
                        state     <= S_PROBE;
                    end
                end
                S_SCAN: begin
                    if (!waiting) begin
                        if (k > N_X) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            ram_raddr <= k[AW-1:0];
                            waiting   <= 1'b1;
                        end
                    end else if (rd_done) begin
                        waiting <= 1'b0;
                        if (!ram_rdata) begin
                            prime_o     <= k[AW-1:0];
                            prime_valid <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (step) begin
                        k     <= k + 1'b1;
                        state <= S_SCAN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SIEVE_PRIME_COUNT_EN
    // Running count of primes emitted in the current run.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (start && ((state == S_IDLE) || (state == S_FIN))) begin
            prime_cnt <= '0;
        end else if (found_prime) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sieve_scheduler.sv
// Directed bench for sieve_scheduler with behavioural RAMs (RD_LAT=2).
module tb_sieve_scheduler;
    import sieve_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned TMAX = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int unsigned checks = 0;
    int unsigned failures = 0;

    // ---------------- instance A: N=30 ----------------
    logic start_a, step_a, busy_a, done_a, we_a, wdata_a, rdata_a, pv_a, preload_a;
    logic [AW-1:0] waddr_a, raddr_a, prime_a;
    logic [255:0] mem_a;
    logic [1:0] pipe_a;
`ifdef SIEVE_PRIME_COUNT_EN
    logic [AW-1:0] cnt_a, cnt_b, cnt_c;
`endif

    sieve_scheduler #(.N(30), .AW(AW), .RD_LAT(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .step(step_a),
        .busy(busy_a), .done(done_a),
        .ram_we(we_a), .ram_waddr(waddr_a), .ram_wdata(wdata_a),
        .ram_raddr(raddr_a), .ram_rdata(rdata_a),
        .prime_o(prime_a), .prime_valid(pv_a)
`ifdef SIEVE_PRIME_COUNT_EN
        , .prime_cnt(cnt_a)
`endif
    );

    always @(posedge clk) begin
        if (preload_a) mem_a <= '1;
        else if (we_a) mem_a[waddr_a] <= wdata_a;
        pipe_a <= {pipe_a[0], mem_a[raddr_a]};
    end
    assign rdata_a = pipe_a[1];

    // ---------------- instance B: N=2 ----------------
    logic start_b, step_b, busy_b, done_b, we_b, wdata_b, rdata_b, pv_b;
    logic [AW-1:0] waddr_b, raddr_b, prime_b;
    logic [255:0] mem_b;
    logic [1:0] pipe_b;

    sieve_scheduler #(.N(2), .AW(AW), .RD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .step(step_b),
        .busy(busy_b), .done(done_b),
        .ram_we(we_b), .ram_waddr(waddr_b), .ram_wdata(wdata_b),
        .ram_raddr(raddr_b), .ram_rdata(rdata_b),
        .prime_o(prime_b), .prime_valid(pv_b)
`ifdef SIEVE_PRIME_COUNT_EN
        , .prime_cnt(cnt_b)
`endif
    );

    always @(posedge clk) begin
        if (we_b) mem_b[waddr_b] <= wdata_b;
        pipe_b <= {pipe_b[0], mem_b[raddr_b]};
    end
    assign rdata_b = pipe_b[1];

`ifdef SIEVE_PRIME_COUNT_EN
    // ---------------- instance C: N=100 ----------------
    logic start_c, step_c, busy_c, done_c, we_c, wdata_c, rdata_c, pv_c;
    logic [AW-1:0] waddr_c, raddr_c, prime_c;
    logic [255:0] mem_c;
    logic [1:0] pipe_c;

    sieve_scheduler #(.N(100), .AW(AW), .RD_LAT(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .step(step_c),
        .busy(busy_c), .done(done_c),
        .ram_we(we_c), .ram_waddr(waddr_c), .ram_wdata(wdata_c),
        .ram_raddr(raddr_c), .ram_rdata(rdata_c),
        .prime_o(prime_c), .prime_valid(pv_c), .prime_cnt(cnt_c)
    );

    always @(posedge clk) begin
        if (we_c) mem_c[waddr_c] <= wdata_c;
        pipe_c <= {pipe_c[0], mem_c[raddr_c]};
    end
    assign rdata_c = pipe_c[1];
`endif

    // Protocol monitors: writes only in CLEAR/MARK, no same-address read/write.
    int unsigned bad_we = 0;
    int unsigned coll = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a && (u_a.state != S_CLEAR) && (u_a.state != S_MARK)) bad_we++;
            if (we_b && (u_b.state != S_CLEAR) && (u_b.state != S_MARK)) bad_we++;
            if (we_a && (waddr_a == raddr_a)) coll++;
            if (we_b && (waddr_b == raddr_b)) coll++;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    int unsigned exp_primes [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
    sieve_state_t trace_ref [TMAX];
    int unsigned ref_len = 0;

    typedef struct {
        string       name;
        bit          preload;
        bit          poke;
        bit          record;
        int unsigned exp_np;
        int unsigned exp_last;
    } run_vec_t;

    // One full run on instance A with step every 5 HOLD cycles.
    task automatic run_a(input run_vec_t v);
        int unsigned np, cyc, since, first_pv, tmis;
        bit stepping, poked_start, poked_step;
        np = 0; cyc = 0; since = 0; first_pv = 0; tmis = 0;
        stepping = 0; poked_start = 0; poked_step = 0;
        if (v.preload) begin
            @(negedge clk); preload_a = 1'b1;
            @(negedge clk); preload_a = 1'b0;
        end
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check({v.name, "_busy_on_start"}, busy_a, 1);
        check({v.name, "_done_cleared"}, done_a, 0);
        while (!done_a && cyc < TMAX) begin
            if (v.record) trace_ref[cyc] = u_a.state;
            else if (cyc >= ref_len || trace_ref[cyc] != u_a.state) tmis++;
            step_a = 1'b0;
            start_a = 1'b0;
            if (pv_a) begin
                if (np < 10) check({v.name, "_prime"}, prime_a, exp_primes[np]);
                if (np == 0) first_pv = cyc;
                np++;
                stepping = 1;
                since = 0;
            end else if (stepping) begin
                since++;
                if (since == 4) begin
                    step_a = 1'b1;
                    stepping = 0;
                end
            end
            if (v.poke && !poked_start && np >= 1 && u_a.state == S_SCAN) begin
                start_a = 1'b1;
                poked_start = 1;
            end
            if (v.poke && !poked_step && u_a.state == S_PROBE && u_a.waiting) begin
                step_a = 1'b1;
                poked_step = 1;
            end
            @(negedge clk);
            cyc++;
        end
        step_a = 1'b0;
        start_a = 1'b0;
        if (v.record) ref_len = cyc;
        else begin
            check({v.name, "_trace_diff"}, tmis, 0);
            check({v.name, "_trace_len"}, cyc, ref_len);
        end
        check({v.name, "_done"}, done_a, 1);
        check({v.name, "_busy_end"}, busy_a, 0);
        check({v.name, "_nprimes"}, np, v.exp_np);
        check({v.name, "_last_prime"}, prime_a, v.exp_last);
        check({v.name, "_latency_ge_clear"}, (first_pv >= 32) ? 1 : 0, 1);
`ifdef SIEVE_PRIME_COUNT_EN
        check({v.name, "_prime_cnt"}, cnt_a, v.exp_np);
`endif
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_state"}, u_a.state, S_IDLE);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_we"}, we_a, 0);
        check({tag, "_wdata"}, wdata_a, 0);
        check({tag, "_waddr"}, waddr_a, 0);
        check({tag, "_raddr"}, raddr_a, 0);
        check({tag, "_prime"}, prime_a, 0);
        check({tag, "_pv"}, pv_a, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_vec_t vecs [3];
        int unsigned cyc, np, nw, maxw, marks;
        bit found, stepping;

        vecs[0] = '{name: "base",    preload: 0, poke: 0, record: 1, exp_np: 10, exp_last: 29};
        vecs[1] = '{name: "preload", preload: 1, poke: 0, record: 0, exp_np: 10, exp_last: 29};
        vecs[2] = '{name: "ignore",  preload: 0, poke: 1, record: 0, exp_np: 10, exp_last: 29};

        rst = 1'b1;
        start_a = 0; step_a = 0; preload_a = 0;
        start_b = 0; step_b = 0;
`ifdef SIEVE_PRIME_COUNT_EN
        start_c = 0; step_c = 0;
`endif
        repeat (3) @(negedge clk);
        check_reset_a("por");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            run_a(vecs[v]);
            if (v == 0) begin
                repeat (5) @(negedge clk);
                check("done_sticky", done_a, 1);
                check("prime_held", prime_a, 29);
            end
        end

        // Reset in the middle of marking multiples of 3.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (u_a.state == S_MARK && u_a.i == 3 && we_a) found = 1;
            else @(negedge clk);
        end
        check("reach_mark_i3", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("mark_rst");
        rst = 1'b0;
        run_a('{name: "restart", preload: 0, poke: 0, record: 0, exp_np: 10, exp_last: 29});

        // N=2: three clear writes, no marking, single prime.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        cyc = 0; np = 0; nw = 0; maxw = 0; marks = 0; stepping = 0;
        while (!done_b && cyc < 200) begin
            step_b = 1'b0;
            if (we_b) begin
                nw++;
                if (waddr_b > maxw) maxw = waddr_b;
            end
            if (u_b.state == S_MARK) marks++;
            if (pv_b) begin
                check("n2_prime", prime_b, 2);
                np++;
                stepping = 1;
            end else if (stepping) begin
                step_b = 1'b1;
                stepping = 0;
            end
            @(negedge clk);
            cyc++;
        end
        step_b = 1'b0;
        check("n2_done", done_b, 1);
        check("n2_clear_writes", nw, 3);
        check("n2_clear_max_addr", maxw, 2);
        check("n2_no_mark", marks, 0);
        check("n2_nprimes", np, 1);
        check("n2_last_prime", prime_b, 2);

`ifdef SIEVE_PRIME_COUNT_EN
        // N=100: 25 primes counted, counter cleared by restart.
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        cyc = 0; stepping = 0;
        while (!done_c && cyc < TMAX) begin
            step_c = 1'b0;
            if (pv_c) stepping = 1;
            else if (stepping) begin
                step_c = 1'b1;
                stepping = 0;
            end
            @(negedge clk);
            cyc++;
        end
        step_c = 1'b0;
        check("n100_done", done_c, 1);
        check("n100_prime_cnt", cnt_c, 25);
        check("n100_last_prime", prime_c, 97);
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        check("n100_cnt_cleared", cnt_c, 0);
`endif

        check("we_only_clear_mark", bad_we, 0);
        check("no_addr_collision", coll, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sieve_scheduler.md
SIEVE_SCHEDULER -- requirements
Module: sieve_scheduler

Interface
REQ-001 SHALL have parameter N, default 999999, meaning the highest integer tested.
REQ-002 SHALL have parameter AW, default 20, meaning the sieve RAM address width, with N < 2^AW.
REQ-003 SHALL have parameter RD_LAT, default 2, meaning RAM read latency in cycles from ram_raddr to ram_rdata, with RD_LAT >= 1.
REQ-004 SHALL use one clock clk; reset rst is synchronous and active-high.
REQ-005 SHALL have ports: clk in 1 system clock; rst in 1 sync active-high reset.
REQ-006 SHALL have ports: start in 1 begin-run pulse; step in 1 advance-to-next-prime pulse (1 s tick).
REQ-007 SHALL have ports: busy out 1 run in progress; done out 1 enumeration finished, sticky until start or rst.
REQ-008 SHALL have RAM ports: ram_we out 1; ram_waddr out AW; ram_wdata out 1; ram_raddr out AW; ram_rdata in 1 (1 = composite).
REQ-009 SHALL have ports: prime_o out AW current prime; prime_valid out 1 one-cycle pulse when prime_o updates.

Function
REQ-010 SHALL implement the FSM states IDLE, CLEAR, PROBE, MARK, SCAN, HOLD, FIN.
REQ-011 IDLE: on start, SHALL go to CLEAR with addr=0 and assert busy.
REQ-012 CLEAR: SHALL write 0 to addresses 0..N, one per cycle (ram_we=1), then set i=2 and go to PROBE.
REQ-013 PROBE: if i*i > N, computed at 2*AW bits with no truncation, SHALL set k=2 and go to SCAN.
REQ-014 PROBE: otherwise SHALL drive ram_raddr=i and wait exactly RD_LAT cycles, holding ram_raddr stable.
REQ-015 PROBE: after the wait, if ram_rdata=0 SHALL set j=2i and go to MARK; otherwise SHALL set i=i+1 and re-evaluate PROBE.
REQ-016 MARK: while j <= N, SHALL write 1 at address j and set j=j+i, one write per cycle.
REQ-017 MARK: when j > N, SHALL deassert ram_we, set i=i+1 and return to PROBE; j additions SHALL be AW+1 bits wide so they cannot wrap.
REQ-018 SCAN: SHALL read address k, wait RD_LAT cycles, then: if rdata=0 go to HOLD; otherwise increment k.
REQ-019 SCAN: when k > N, SHALL go to FIN.
REQ-020 HOLD entry: SHALL load prime_o=k and pulse prime_valid for one cycle.
REQ-021 HOLD: on step, SHALL set k=k+1 and return to SCAN; step outside HOLD SHALL be ignored.
REQ-022 FIN: SHALL set done=1 and busy=0, hold prime_o at the last prime, and accept start to rerun from CLEAR, clearing done.
REQ-023 start while busy SHALL be ignored.
REQ-024 ram_we SHALL be asserted only in CLEAR and MARK.
REQ-025 ram_raddr and ram_waddr SHALL never both address the same location in one cycle.
REQ-026 Latency: the first prime_valid SHALL occur no earlier than the CLEAR length (N+1 cycles) plus the sieve phase.

Reset
REQ-027 On rst at any clock edge, including mid-CLEAR, mid-MARK or mid-wait, the block SHALL go to IDLE next cycle.
REQ-028 After rst: busy=0, done=0, ram_we=0, ram_wdata=0, ram_waddr=0, ram_raddr=0, prime_o=0, prime_valid=0.
REQ-029 A new start after rst SHALL redo CLEAR, so no stale RAM contents affect results.

Configuration
REQ-030 With macro SIEVE_PRIME_COUNT_EN defined, the block SHALL add output prime_cnt (AW bits), reset to 0, cleared on start and incremented with each prime_valid.
REQ-031 Without SIEVE_PRIME_COUNT_EN, the port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-032 A shared package sieve_pkg SHALL hold the state enum type, the default AW/N/RD_LAT constants, and the 2*AW square-width localparam.
REQ-033 The read-wait SHALL be a sub-module sieve_rd_wait: a load/countdown counter of RD_LAT with a done pulse, reused by PROBE and SCAN.
REQ-034 The RAM SHALL remain external to the block.

Verification
REQ-035 N=30, RD_LAT=2, behavioural RAM, start, step every 5 cycles in HOLD: primes SHALL be 2,3,5,7,11,13,17,19,23,29 with one prime_valid each, then done=1 and prime_o=29.
REQ-036 Preload RAM with all 1s, then start: CLEAR SHALL zero it, giving the same 10 primes as REQ-035.
REQ-037 rst asserted during MARK of i=3: the next cycle SHALL show IDLE with ram_we=0, and a restart SHALL yield the correct sequence.
REQ-038 start pulsed during SCAN, and step pulsed during PROBE: both SHALL have no effect, verified by an unchanged state trace.
REQ-039 N=2 edge case: CLEAR writes addresses 0..2 and PROBE goes directly to SCAN (4>2); the only prime SHALL be 2, then done.
REQ-040 With SIEVE_PRIME_COUNT_EN, N=100: prime_cnt SHALL equal 25 at done, and restart SHALL clear it to 0.
